// File: rtl/data_mem_responder_if.sv
// Halfword data-memory bus between the execute/memory stage (master)
// and the memory-side responder (slave).
interface data_mem_responder_if;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [31:0] data_mem_addr_i;
  logic [15:0] data_mem_i;
  logic [15:0] data_mem_o;
  logic        rd_valid_o;
  logic [31:0] rdata_word_o;
  logic        rdata_valid_o;
  logic        pair_err_o;
  logic        addr_err_o;

  modport master (
    output mem_re_i, mem_we_i, data_mem_addr_i, data_mem_i,
    input  data_mem_o, rd_valid_o, rdata_word_o, rdata_valid_o,
           pair_err_o, addr_err_o
  );

  modport slave (
    input  mem_re_i, mem_we_i, data_mem_addr_i, data_mem_i,
    output data_mem_o, rd_valid_o, rdata_word_o, rdata_valid_o,
           pair_err_o, addr_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Halfword memory responder: services single beats with one cycle of read
// latency, pairs consecutive beats, and assembles read pairs into 32-bit words.
module data_mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic clk_i,
  input logic rst_i,
  data_mem_responder_if.slave bus
);

  localparam int          DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [32:0] LIMIT = 33'(1) << (ADDR_WIDTH + 1);

  localparam logic [0:0] ST_BEAT0 = 1'b0;
  localparam logic [0:0] ST_BEAT1 = 1'b1;

  logic [15:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  bad_beat;
  logic                  beat;
  logic                  wr_beat;
  logic                  rd_beat;
  logic                  type_match;
  logic                  rd_first;
  logic                  rd_second;

  logic [0:0]  state;
  logic        pair_wr;
  logic        rd_first_q;
  logic        rd_second_q;
  logic [15:0] upper_q;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  always_comb begin
    offset       = bus.data_mem_addr_i - BASE_ADDR;
    idx          = offset[ADDR_WIDTH:1];
    out_of_range = ({1'b0, offset} >= LIMIT);
    misaligned   = offset[0];
    bad_beat     = out_of_range | misaligned;
    wr_beat      = bus.mem_we_i;
    rd_beat      = bus.mem_re_i & ~bus.mem_we_i;
    beat         = bus.mem_re_i | bus.mem_we_i;
    type_match   = (state == ST_BEAT1) && (pair_wr == wr_beat);
    rd_second    = rd_beat & type_match;
    rd_first     = rd_beat & ~type_match;
  end

  // Storage is never cleared; a write during reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_beat && !bad_beat) begin
      mem[idx] <= bus.data_mem_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.data_mem_o <= 16'h0000;
      bus.rd_valid_o <= 1'b0;
      bus.addr_err_o <= 1'b0;
    end else begin
      bus.rd_valid_o <= rd_beat;
      bus.addr_err_o <= beat & bad_beat;
      if (rd_beat) begin
        bus.data_mem_o <= bad_beat ? 16'h0000 : mem[idx];
      end
    end
  end

  // A beat whose type disagrees with the open pair restarts the pair.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_BEAT0;
      pair_wr        <= 1'b0;
      bus.pair_err_o <= 1'b0;
    end else begin
      bus.pair_err_o <= 1'b0;
      if (beat) begin
        if (type_match) begin
          state <= ST_BEAT0;
        end else begin
          bus.pair_err_o <= (state == ST_BEAT1);
          pair_wr        <= wr_beat;
          state          <= ST_BEAT1;
        end
      end
    end
  end

  // Beat roles travel alongside the read data so the word is built when
  // each halfword lands on data_mem_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_first_q        <= 1'b0;
      rd_second_q       <= 1'b0;
      upper_q           <= 16'h0000;
      bus.rdata_word_o  <= 32'h0000_0000;
      bus.rdata_valid_o <= 1'b0;
    end else begin
      rd_first_q        <= rd_first;
      rd_second_q       <= rd_second;
      bus.rdata_valid_o <= rd_second_q;
      if (rd_first_q) begin
        upper_q <= bus.data_mem_o;
      end
      if (rd_second_q) begin
        bus.rdata_word_o <= {upper_q, bus.data_mem_o};
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized traffic checked against a beat-level reference model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_WIDTH(10),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain halfword array plus the notion of an "open pair".
  logic [15:0] ref_mem [1024];
  bit          pair_open = 1'b0;
  bit          open_wr   = 1'b0;
  logic [15:0] first_data = 16'h0000;
  bit          due_valid = 1'b0;
  logic [31:0] due_word  = 32'h0;

  bit          exp_rd_valid    = 1'b0;
  bit          exp_rdata_valid = 1'b0;
  bit          exp_pair_err    = 1'b0;
  bit          exp_addr_err    = 1'b0;
  logic [15:0] exp_dout        = 16'h0000;
  logic [31:0] exp_word        = 32'h0;

  // Drive one cycle, advance the model, and return 1 time unit after the edge.
  task automatic step(input bit re, input bit we, input logic [31:0] addr,
                      input logic [15:0] d, input bit r);
    bit          bad;
    bit          is_read;
    int          idx;
    logic [15:0] rdat;
    bit          new_valid;
    logic [31:0] new_word;
    bus.mem_re_i        = re;
    bus.mem_we_i        = we;
    bus.data_mem_addr_i = addr;
    bus.data_mem_i      = d;
    rst                 = r;
    bad       = addr[0] || (addr >= 32'h0000_0800);
    idx       = bad ? 0 : int'(addr >> 1);
    is_read   = re && !we;
    rdat      = bad ? 16'h0000 : ref_mem[idx];
    new_valid = 1'b0;
    new_word  = 32'h0;
    exp_pair_err = 1'b0;
    if (r) begin
      exp_rd_valid    = 1'b0;
      exp_dout        = 16'h0000;
      exp_addr_err    = 1'b0;
      exp_rdata_valid = 1'b0;
      exp_word        = 32'h0;
      pair_open       = 1'b0;
      due_valid       = 1'b0;
    end else begin
      exp_rd_valid = is_read;
      if (is_read) exp_dout = rdat;
      exp_addr_err = (re || we) && bad;
      if (we && !bad) ref_mem[idx] = d;
      exp_rdata_valid = due_valid;
      if (due_valid) exp_word = due_word;
      if (re || we) begin
        if (pair_open && (open_wr == we)) begin
          pair_open = 1'b0;
          if (is_read) begin
            new_valid = 1'b1;
            new_word  = {first_data, rdat};
          end
        end else begin
          if (pair_open) exp_pair_err = 1'b1;
          pair_open = 1'b1;
          open_wr   = we;
          if (is_read) first_data = rdat;
        end
      end
      due_valid = new_valid;
      due_word  = new_word;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 1024; i++) begin
      step(1'b0, 1'b1, 32'(i * 2), 16'($urandom), 1'b0);
      checks++;
      if (bus.addr_err_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_addr_err: got %b expected 0 at index %0d", bus.addr_err_o, i);
      end
    end
    idle();
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 32'h10, 16'hAAAA, 1'b0);
    step(1'b0, 1'b1, 32'h12, 16'hBBBB, 1'b0);
    step(1'b1, 1'b0, 32'h10, 16'h0, 1'b1);
    checks++;
    if (bus.data_mem_o !== 16'h0000 || bus.rd_valid_o !== 1'b0 || bus.rdata_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got dout=%h rdv=%b wv=%b expected 0000/0/0",
               bus.data_mem_o, bus.rd_valid_o, bus.rdata_valid_o);
    end
    step(1'b1, 1'b0, 32'h10, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'hAAAA) begin
      errors++;
      $display("[TB] FAIL reset_keeps_mem_lo: got %h expected AAAA", bus.data_mem_o);
    end
    step(1'b1, 1'b0, 32'h12, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'hBBBB) begin
      errors++;
      $display("[TB] FAIL reset_keeps_mem_hi: got %h expected BBBB", bus.data_mem_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b1 || bus.rdata_word_o !== 32'hAAAA_BBBB) begin
      errors++;
      $display("[TB] FAIL reset_word: got v=%b w=%h expected 1/AAAABBBB",
               bus.rdata_valid_o, bus.rdata_word_o);
    end
  endtask

  task automatic test_read_pair();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 32'h22, 16'h5678, 1'b0);
    step(1'b0, 1'b1, 32'h20, 16'h1234, 1'b0);
    step(1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'h1234 || bus.rd_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pair_beat0: got %h/%b expected 1234/1", bus.data_mem_o, bus.rd_valid_o);
    end
    step(1'b1, 1'b0, 32'h22, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'h5678 || bus.rdata_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pair_beat1: got %h/v=%b expected 5678/0", bus.data_mem_o, bus.rdata_valid_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b1 || bus.rdata_word_o !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL pair_word: got v=%b w=%h expected 1/12345678",
               bus.rdata_valid_o, bus.rdata_word_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b0 || bus.rdata_word_o !== 32'h1234_5678 || bus.rd_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pair_hold: got v=%b w=%h rdv=%b expected 0/12345678/0",
               bus.rdata_valid_o, bus.rdata_word_o, bus.rd_valid_o);
    end
  endtask

  task automatic test_addr_err();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 32'h21, 16'h0, 1'b0);
    checks++;
    if (bus.addr_err_o !== 1'b1 || bus.data_mem_o !== 16'h0000 || bus.rd_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misaligned_read: got err=%b dout=%h rdv=%b expected 1/0000/1",
               bus.addr_err_o, bus.data_mem_o, bus.rd_valid_o);
    end
    step(1'b0, 1'b1, 32'h21, 16'hFFFF, 1'b0);
    checks++;
    if (bus.addr_err_o !== 1'b1 || bus.pair_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misaligned_write: got err=%b perr=%b expected 1/1", bus.addr_err_o, bus.pair_err_o);
    end
    step(1'b0, 1'b1, 32'h800, 16'hFFFF, 1'b0);
    checks++;
    if (bus.addr_err_o !== 1'b1 || bus.pair_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_of_range: got err=%b perr=%b expected 1/0", bus.addr_err_o, bus.pair_err_o);
    end
    step(1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'h1234 || bus.addr_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_write_dropped: got %h err=%b expected 1234/0", bus.data_mem_o, bus.addr_err_o);
    end
    step(1'b1, 1'b0, 32'h22, 16'h0, 1'b0);
    idle();
    idle();
  endtask

  task automatic test_pair_err();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
    step(1'b0, 1'b1, 32'h22, 16'h9999, 1'b0);
    checks++;
    if (bus.pair_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pair_err_pulse: got %b expected 1", bus.pair_err_o);
    end
    step(1'b0, 1'b1, 32'h20, 16'h4321, 1'b0);
    checks++;
    if (bus.pair_err_o !== 1'b0 || bus.rdata_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pair_err_complete: got perr=%b v=%b expected 0/0", bus.pair_err_o, bus.rdata_valid_o);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (bus.rdata_valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_pair_no_word: got %b expected 0 (idle %0d)", bus.rdata_valid_o, i);
      end
    end
    step(1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
    step(1'b1, 1'b0, 32'h22, 16'h0, 1'b0);
    checks++;
    if (bus.pair_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pair_err_spurious: got %b expected 0", bus.pair_err_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b1 || bus.rdata_word_o !== 32'h4321_9999) begin
      errors++;
      $display("[TB] FAIL pair_err_word: got v=%b w=%h expected 1/43219999",
               bus.rdata_valid_o, bus.rdata_word_o);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 32'h30, 16'hBEEF, 1'b0);
    checks++;
    if (bus.rd_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_no_read: got rdv=%b expected 0", bus.rd_valid_o);
    end
    step(1'b1, 1'b0, 32'h30, 16'h0, 1'b0);
    checks++;
    if (bus.data_mem_o !== 16'hBEEF || bus.rd_valid_o !== 1'b1 || bus.pair_err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_write_wins: got %h rdv=%b perr=%b expected BEEF/1/1",
               bus.data_mem_o, bus.rd_valid_o, bus.pair_err_o);
    end
    step(1'b1, 1'b0, 32'h32, 16'h0, 1'b0);
    idle();
    idle();
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
    step(1'b1, 1'b0, 32'h22, 16'h0, 1'b0);
    step(1'b1, 1'b0, 32'h40, 16'h0, 1'b0);
    checks++;
    if (bus.rdata_valid_o !== 1'b1 || bus.rdata_word_o !== 32'h4321_9999) begin
      errors++;
      $display("[TB] FAIL b2b_first_word: got v=%b w=%h expected 1/43219999",
               bus.rdata_valid_o, bus.rdata_word_o);
    end
    step(1'b1, 1'b0, 32'h42, 16'h0, 1'b1);
    checks++;
    if (bus.rdata_valid_o !== 1'b0 || bus.rd_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_reset_suppress: got v=%b rdv=%b expected 0/0", bus.rdata_valid_o, bus.rd_valid_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_no_second_word: got %b expected 0", bus.rdata_valid_o);
    end
    step(1'b1, 1'b0, 32'h40, 16'h0, 1'b0);
    step(1'b1, 1'b0, 32'h42, 16'h0, 1'b0);
    checks++;
    if (bus.pair_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_fsm_beat0: got perr=%b expected 0", bus.pair_err_o);
    end
    idle();
    checks++;
    if (bus.rdata_valid_o !== 1'b1 || bus.rdata_word_o !== {ref_mem[32], ref_mem[33]}) begin
      errors++;
      $display("[TB] FAIL b2b_after_reset_word: got v=%b w=%h expected 1/%h",
               bus.rdata_valid_o, bus.rdata_word_o, {ref_mem[32], ref_mem[33]});
    end
  endtask

  task automatic test_random();
    bit          re;
    bit          we;
    bit          r;
    logic [31:0] addr;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      re   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 2) == 0);
      r    = ($urandom_range(0, 49) == 0);
      kind = $urandom_range(0, 19);
      if (kind == 0)      addr = 32'(2 * $urandom_range(0, 1023) + 1);
      else if (kind == 1) addr = 32'h800 + 32'($urandom_range(0, 255));
      else if (kind == 2) addr = 32'hFFFF_FFFE;
      else                addr = 32'(2 * $urandom_range(0, 15));
      step(re, we, addr, 16'($urandom), r);
      checks++;
      if (bus.rd_valid_o !== exp_rd_valid || bus.data_mem_o !== exp_dout ||
          bus.addr_err_o !== exp_addr_err || bus.pair_err_o !== exp_pair_err ||
          bus.rdata_valid_o !== exp_rdata_valid || bus.rdata_word_o !== exp_word) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d: got rdv=%b d=%h ae=%b pe=%b wv=%b w=%h expected %b/%h/%b/%b/%b/%h",
                 n, bus.rd_valid_o, bus.data_mem_o, bus.addr_err_o, bus.pair_err_o,
                 bus.rdata_valid_o, bus.rdata_word_o, exp_rd_valid, exp_dout,
                 exp_addr_err, exp_pair_err, exp_rdata_valid, exp_word);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 16'h0, 1'b1);
    test_fill();
    test_reset();
    test_read_pair();
    test_addr_err();
    test_pair_err();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
